serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b: one bit per clock, LSB first, result latched on the final bit.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_a_q, shift_a_d;
   logic [WIDTH-1:0] shift_b_q, shift_b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic             cell_d, cell_bout;

   full_subtractor u_cell (
      .x    (shift_a_q[0]),
      .y    (shift_b_q[0]),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_comb begin
      state_d   = state_q;
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      res_d     = res_q;
      diff_d    = diff_q;
      cnt_d     = cnt_q;
      borrow_d  = borrow_q;
      bout_d    = bout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               shift_a_d = a;
               shift_b_d = b;
               borrow_d  = 1'b0;
               cnt_d     = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            shift_a_d = shift_a_q >> 1;
            shift_b_d = shift_b_q >> 1;
            // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
            res_d     = {cell_d, res_q[WIDTH-1:1]};
            borrow_d  = cell_bout;
            cnt_d     = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               diff_d  = {cell_d, res_q[WIDTH-1:1]};
               bout_d  = cell_bout;
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         shift_a_q <= '0;
         shift_b_q <= '0;
         res_q     <= '0;
         diff_q    <= '0;
         cnt_q     <= '0;
         borrow_q  <= 1'b0;
         bout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
         res_q     <= res_d;
         diff_q    <= diff_d;
         cnt_q     <= cnt_d;
         borrow_q  <= borrow_d;
         bout_q    <= bout_d;
      end
   end

   assign diff       = diff_q;
   assign borrow_out = bout_q;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner sequences, random ops.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;
   int accepts = 0;
   int dones = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .diff       (diff),
      .borrow_out (borrow_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (done) dones++;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         bo;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain modular arithmetic on integers.
   function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned r;
      r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
      return r[W-1:0];
   endfunction

   function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
      return int'(x) < int'(y);
   endfunction

   // Issue one start pulse and check latency, hold behaviour and result.
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input string tag);
      logic [W-1:0] prev;
      logic         held;
      int           k;
      @(negedge clk);
      a = xa;
      b = xb;
      start = 1'b1;
      prev = diff;
      @(negedge clk);
      start = 1'b0;
      accepts++;
      a = ~xa;
      b = ~xb;
      chk({tag, " busy"}, busy, 1'b1);
      held = 1'b1;
      k = 0;
      while (!done && k < 4 * W) begin
         if (diff !== prev) held = 1'b0;
         @(negedge clk);
         k++;
      end
      chk({tag, " hold"}, held, 1'b1);
      chk({tag, " latency"}, k, W);
      chk({tag, " diff"}, diff, ref_diff(xa, xb));
      chk({tag, " borrow"}, borrow_out, ref_borrow(xa, xb));
      @(negedge clk);
      chk({tag, " done width"}, {busy, done}, 2'b00);
   endtask

   initial begin
      vec_t vecs[6];
      vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0};
      vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1};
      vecs[2] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1};
      vecs[3] = '{a: 8'hA5, b: 8'hA5, d: 8'h00, bo: 1'b0};
      vecs[4] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bo: 1'b0};
      vecs[5] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bo: 1'b1};

      #12;
      chk("reset outs", {diff, borrow_out, busy, done}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, "table");
         chk("table const diff", diff, vecs[i].d);
         chk("table const borrow", borrow_out, vecs[i].bo);
      end

      // Start held high with operands changing every cycle.
      begin
         logic [W-1:0] qd[$];
         logic         qb[$];
         logic [W-1:0] ra, rb;
         int           seen = 0;
         for (int c = 0; c < 3 * (W + 2); c++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            a = ra;
            b = rb;
            start = 1'b1;
            if (c % (W + 2) == 0) begin
               qd.push_back(ref_diff(ra, rb));
               qb.push_back(ref_borrow(ra, rb));
               accepts++;
            end
            @(negedge clk);
            chk("stream done", done, (c % (W + 2)) == W);
            if (done && qd.size() > 0) begin
               seen++;
               chk("stream diff", diff, qd.pop_front());
               chk("stream borrow", borrow_out, qb.pop_front());
            end
         end
         start = 1'b0;
         chk("stream count", seen, 3);
      end

      // Reset in the middle of a shift.
      begin
         int  k;
         logic saw_done = 1'b0;
         @(negedge clk);
         a = 8'h37;
         b = 8'h12;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (k = 0; k < 4; k++) @(negedge clk);
         rst_n = 1'b0;
         #1;
         chk("abort outs", {diff, borrow_out, busy, done}, '0);
         for (k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
         end
         chk("abort no done", saw_done, 1'b0);
         rst_n = 1'b1;
         run_op(8'h10, 8'h01, "post reset");
         chk("post reset diff", diff, 8'h0F);
      end

      for (int n = 0; n < 300; n++) run_op(W'($urandom), W'($urandom), "random");

      chk("done count", dones, accepts);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
